// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: machine widths, fetch queue entry and the opcode map used by decode.
package riscv_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ILEN    = 32;
  localparam int unsigned PC_STEP = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle: imem request/response channels, redirect and decoder handshake.
interface inst_fetch_if;
  import riscv_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [ILEN-1:0] inst_out;
  logic [XLEN-1:0] inst_pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_out, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_out, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous instruction queue of {pc, inst}; push+pop legal when full, flush beats push.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned  DEPTH     = 2,
  parameter fetch_entry_t RST_ENTRY = '0,
  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[AW'(i)] <= RST_ENTRY;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC/credit control toward imem, in-order response queue toward decode,
// and redirect handling that drains stale in-flight responses.
module inst_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     QDEPTH   = 2
) (
  input logic          clk,
  input logic          rst,
  inst_fetch_if.master bus
);

  localparam int unsigned  CW    = $clog2(QDEPTH + 1);
  localparam logic [0:0]   RUN   = 1'b0;
  localparam logic [0:0]   DRAIN = 1'b1;
  localparam fetch_entry_t RST_ENTRY = '{pc: RESET_PC, inst: '0};

  typedef logic [CW:0] credit_t;

  logic [0:0]      state;
  logic [0:0]      state_nxt;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] redir_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_nxt;
  logic [CW-1:0]   count;
  logic            req_fire;
  logic            rsp_take;
  logic            rsp_push;
  logic            inst_pop;
  logic            fifo_full;
  logic            fifo_empty;
  fetch_entry_t    rsp_entry;
  fetch_entry_t    head;

  assign redir_pc = bus.redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};

  // Queue slots are reserved at request time so every response always has room.
  assign bus.imem_req_valid = !rst && (state == RUN) && !bus.redirect_valid &&
                              ((credit_t'(outstanding) + credit_t'(count)) < credit_t'(QDEPTH));
  assign bus.imem_req_addr  = fetch_pc;

  assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_take  = bus.imem_rsp_valid && (outstanding != '0);
  assign rsp_push  = rsp_take && (state == RUN) && !bus.redirect_valid;
  assign inst_pop  = bus.inst_valid && bus.inst_ready;
  assign rsp_entry = '{pc: rsp_pc, inst: bus.imem_rsp_data};

  assign bus.inst_valid = !fifo_empty;
  assign bus.inst_out   = head.inst;
  assign bus.inst_pc    = head.pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    outstanding_nxt = outstanding + CW'(req_fire) - CW'(rsp_take);
    state_nxt       = state;
    if (bus.redirect_valid)
      state_nxt = (outstanding_nxt == '0) ? RUN : DRAIN;
    else if ((state == DRAIN) && (outstanding_nxt == '0))
      state_nxt = RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (bus.redirect_valid) begin
        fetch_pc <= redir_pc;
        rsp_pc   <= redir_pc;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(PC_STEP);
        if (rsp_push) rsp_pc   <= rsp_pc + XLEN'(PC_STEP);
      end
    end
  end

  fetch_fifo #(
    .DEPTH     (QDEPTH),
    .RST_ENTRY (RST_ENTRY)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_push),
    .push_data (rsp_entry),
    .pop       (inst_pop),
    .flush     (bus.redirect_valid),
    .head      (head),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
    bus.imem_rsp_valid |-> (outstanding != '0));

  a_push_has_room: assert property (@(posedge clk) disable iff (rst)
    rsp_push |-> (!fifo_full || inst_pop));

endmodule
